// File: rtl/rr_arb_mux_4.sv
`default_nettype none
// ============================================================================
// Module     : rr_arb_mux_4
// Description: 4-requester round-robin arbiter with a registered output word
//              and registered grant index (out_sel).
// Revision   : 1.0 - initial release
// ============================================================================
module rr_arb_mux_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel
);

    localparam logic [1:0] C_PTR_RESET = 2'd3;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [1:0]       out_sel_q,   out_sel_d;
    logic [1:0]       last_ptr_q,  last_ptr_d;

    logic             w_accept;
    logic             w_has_gnt;
    logic [1:0]       w_gnt_idx;
    logic [1:0]       w_cand;
    logic [WIDTH-1:0] w_gnt_data;

    assign w_accept = ~out_valid_q | out_ready;

    // Search starts one past the last winner; 2-bit add wraps 3 -> 0.
    always_comb begin
        w_has_gnt = 1'b0;
        w_gnt_idx = 2'd0;
        w_cand    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_cand = last_ptr_q + 2'(k);
            if (!w_has_gnt && in_valid[w_cand]) begin
                w_has_gnt = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    always_comb begin
        case (w_gnt_idx)
            2'd0:    w_gnt_data = d0;
            2'd1:    w_gnt_data = d1;
            2'd2:    w_gnt_data = d2;
            default: w_gnt_data = d3;
        endcase
    end

    for (genvar i = 0; i < 4; i++) begin : g_ready
        assign in_ready[i] = w_accept & w_has_gnt & (w_gnt_idx == 2'(i));
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        last_ptr_d  = last_ptr_q;
        if (w_accept) begin
            if (w_has_gnt) begin
                out_valid_d = 1'b1;
                out_data_d  = w_gnt_data;
                out_sel_d   = w_gnt_idx;
                last_ptr_d  = w_gnt_idx;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
            last_ptr_q  <= C_PTR_RESET;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            last_ptr_q  <= last_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux_4.sv
`default_nettype none
// ============================================================================
// Module     : tb_rr_arb_mux_4
// Description: Scoreboard bench for rr_arb_mux_4 (WIDTH = 4).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_rr_arb_mux_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_valid;
    logic [3:0] td [4];
    logic [3:0] in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_sel;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: contents the output register should hold after the next edge.
    logic       m_valid;
    logic [3:0] m_data;
    logic [1:0] m_sel;
    logic [1:0] m_last;
    logic [5:0] sb [$];

    rr_arb_mux_4 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .d0        (td[0]),
        .d1        (td[1]),
        .d2        (td[2]),
        .d3        (td[3]),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] model_grant(input logic [3:0] v, input logic [1:0] last);
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] c;
            c = 2'((int'(last) + k) % 4);
            if (v[c]) return {1'b1, c};
        end
        return 3'b000;
    endfunction

    function automatic logic [3:0] model_ready();
        logic [2:0] g;
        g = model_grant(in_valid, m_last);
        if ((!m_valid || out_ready) && g[2]) return 4'b0001 << g[1:0];
        return 4'b0000;
    endfunction

    // Advance the reference across one rising edge; queue the word a transfer will produce.
    task automatic model_step();
        logic [2:0] g;
        g = model_grant(in_valid, m_last);
        if (!m_valid || out_ready) begin
            if (g[2]) begin
                m_valid = 1'b1;
                m_data  = td[g[1:0]];
                m_sel   = g[1:0];
                m_last  = g[1:0];
                sb.push_back({g[1:0], td[g[1:0]]});
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 4'h0;
        m_sel   = 2'd0;
        m_last  = 2'd3;
        sb.delete();
    endtask

    task automatic test_reset();
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        td[0] = 4'h0; td[1] = 4'h0; td[2] = 4'h0; td[3] = 4'h0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_async: got v=%b sel=%0d data=%h want v=0 sel=0 data=0",
                     out_valid, out_sel, out_data);
        end
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 0000", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_contention();
        logic [1:0] es [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] ed [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
        logic [5:0] e;
        td[0] = 4'h1; td[1] = 4'h2; td[2] = 4'h3; td[3] = 4'h4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 4'b1111; out_ready = 1'b1;
            #1;
            n_checks++;
            if (in_ready !== (4'b0001 << es[i])) begin
                n_fail++;
                $display("FAIL contention_ready[%0d]: got %b want %b", i, in_ready, 4'b0001 << es[i]);
            end
            model_step();
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== es[i] || out_data !== ed[i] || {out_sel, out_data} !== e) begin
                n_fail++;
                $display("FAIL contention_out[%0d]: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                         i, out_valid, out_sel, out_data, es[i], ed[i]);
            end
        end
    endtask

    task automatic test_single_source();
        logic [5:0] e;
        td[2] = 4'hA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 4'b0100; out_ready = 1'b1;
            #1;
            n_checks++;
            if (in_ready !== 4'b0100 || in_ready !== model_ready()) begin
                n_fail++;
                $display("FAIL single_ready[%0d]: got %b want 0100", i, in_ready);
            end
            model_step();
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || {out_sel, out_data} !== e || out_sel !== 2'd2 || out_data !== 4'hA) begin
                n_fail++;
                $display("FAIL single_out[%0d]: got v=%b sel=%0d data=%h want v=1 sel=2 data=a",
                         i, out_valid, out_sel, out_data);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] vs [4] = '{4'b1000, 4'b1001, 4'b1001, 4'b1001};
        logic [1:0] es [4] = '{2'd3, 2'd0, 2'd3, 2'd0};
        logic [5:0] e;
        td[0] = 4'h5; td[3] = 4'hC;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = vs[i]; out_ready = 1'b1;
            #1;
            n_checks++;
            if (in_ready !== model_ready()) begin
                n_fail++;
                $display("FAIL wrap_ready[%0d]: got %b want %b", i, in_ready, model_ready());
            end
            model_step();
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if ({out_sel, out_data} !== e || out_sel !== es[i]) begin
                n_fail++;
                $display("FAIL wrap_out[%0d]: got sel=%0d data=%h want sel=%0d data=%h",
                         i, out_sel, out_data, es[i], e[3:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] e;
        logic [1:0] held_sel;
        logic [3:0] held_data;
        td[0] = 4'h1; td[1] = 4'h2; td[2] = 4'h3; td[3] = 4'h4;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid  = 4'b1111;
            out_ready = (i >= 1 && i <= 3) ? 1'b0 : 1'b1;
            held_sel  = out_sel;
            held_data = out_data;
            #1;
            n_checks++;
            if (in_ready !== model_ready()) begin
                n_fail++;
                $display("FAIL bp_ready[%0d]: got %b want %b", i, in_ready, model_ready());
            end
            model_step();
            @(posedge clk); #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (out_valid !== 1'b1 || {out_sel, out_data} !== e) begin
                    n_fail++;
                    $display("FAIL bp_out[%0d]: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                             i, out_valid, out_sel, out_data, e[5:4], e[3:0]);
                end
            end else begin
                n_checks++;
                if (out_valid !== 1'b1 || out_sel !== held_sel || out_data !== held_data) begin
                    n_fail++;
                    $display("FAIL bp_stall[%0d]: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                             i, out_valid, out_sel, out_data, held_sel, held_data);
                end
            end
        end
    endtask

    task automatic test_drain_reset();
        logic [5:0] e;
        @(negedge clk);
        in_valid = 4'b0000; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL drain_ready: got %b want 0000", in_ready);
        end
        model_step();
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_valid !== m_valid) begin
            n_fail++;
            $display("FAIL drain_valid: got %b want 0", out_valid);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 4'b1111; out_ready = 1'b1;
            #1;
            model_step();
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if ({out_sel, out_data} !== e) begin
                n_fail++;
                $display("FAIL stream_out[%0d]: got sel=%0d data=%h want sel=%0d data=%h",
                         i, out_sel, out_data, e[5:4], e[3:0]);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 4'h0) begin
            n_fail++;
            $display("FAIL midreset: got v=%b sel=%0d data=%h want v=0 sel=0 data=0",
                     out_valid, out_sel, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 4'b0110; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0010 || in_ready !== model_ready()) begin
            n_fail++;
            $display("FAIL post_reset_ready: got %b want 0010", in_ready);
        end
        model_step();
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd1 || {out_sel, out_data} !== e) begin
            n_fail++;
            $display("FAIL post_reset_out: got v=%b sel=%0d data=%h want v=1 sel=1 data=%h",
                     out_valid, out_sel, out_data, e[3:0]);
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_source();
        test_wrap();
        test_backpressure();
        test_drain_reset();
        @(negedge clk);
        in_valid = 4'b0000;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
